// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to compute MUL* products in a single cycle; divides stay iterative.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned W2 = 2 * XLEN;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [XLEN-1:0]   mag_a_q, mag_b_q;
    logic [W2-1:0]     acc_q;
    logic [CW-1:0]     count_q;

    logic              a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [W2-1:0]     mul_next;
    logic [XLEN:0]     div_top;
    logic [XLEN-1:0]   div_diff;
    logic [W2-1:0]     div_next;
    logic [W2-1:0]     prod;
    logic [XLEN-1:0]   quot_s, rem_s;
    logic [XLEN-1:0]   fix_res;

    assign in_ready = (state_q == StIdle) && !flush;
    assign busy     = (state_q != StIdle);

    always_comb begin
        // MULHSU treats only rs1 as signed; MUL's low word is sign-agnostic.
        a_signed = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
        b_signed = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
        sign_a   = a_signed && a_q[XLEN-1];
        sign_b   = b_signed && b_q[XLEN-1];
        mag_a    = sign_a ? -a_q : a_q;
        mag_b    = sign_b ? -b_q : b_q;

        special     = 1'b0;
        special_res = '0;
        if (op_q[2] && (b_q == '0)) begin
            special     = 1'b1;
            special_res = op_q[1] ? a_q : '1;
        end else if (((op_q == 3'd4) || (op_q == 3'd6)) && (a_q == MinNeg) && (b_q == '1)) begin
            special     = 1'b1;
            special_res = op_q[1] ? '0 : a_q;
        end

        mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Shifted partial remainder needs one extra bit before the trial subtract.
        div_top  = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_top[XLEN-1:0] - mag_b_q;
        if (div_top >= {1'b0, mag_b_q}) begin
            div_next = {div_diff, acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end

        prod   = (sign_a ^ sign_b) ? -acc_q : acc_q;
        quot_s = (sign_a ^ sign_b) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = sign_a ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];

        case (op_q)
            3'd0:                fix_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_res = prod[W2-1:XLEN];
            3'd4, 3'd5:          fix_res = quot_s;
            default:             fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        state_q <= StPrep;
                    end
                end
                StPrep: begin
                    if (special) begin
                        result    <= special_res;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        mag_a_q <= mag_a;
                        mag_b_q <= mag_b;
                        count_q <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        if (!op_q[2]) begin
                            acc_q   <= W2'(mag_a) * W2'(mag_b);
                            state_q <= StFix;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, mag_a};
                            state_q <= StCalc;
                        end
`else
                        // Multiplier (mag_b) or dividend (mag_a) starts in the low half.
                        acc_q   <= op_q[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                        state_q <= StCalc;
`endif
                    end
                end
                StCalc: begin
                    acc_q   <= op_q[2] ? div_next : mul_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(XLEN - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    result    <= fix_res;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, reset/flush/backpressure, random ops.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          stall;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] p;
        int          sx, sy;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin p = longint'($signed(x)) * longint'($signed(y)); return p[63:32]; end
            3'd2: begin p = longint'($signed(x)) * longint'({32'b0, y}); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return sx / sy;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return sx % sy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit is_div = (o >= 3'd4);
        bit signed_div = (o == 3'd4) || (o == 3'd6);
        if (is_div && y == 0) return 2;
        if (signed_div && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) return 3;
`endif
        return 35;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit expect_out, input int stall);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
            return;
        end
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        if (expect_out) q.push_back('{model(o, x, y), exp_lat(o, x, y), stall, cyc});
    endtask

    // Monitor: pops the scoreboard when out_valid rises, then applies the entry's backpressure.
    exp_t cur;
    bit   active = 1'b0;
    bit   hs = 1'b0;
    int   stall_left = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hs) begin
                check("idle_after_handshake_valid", 32'(out_valid), 32'd0);
                check("idle_after_handshake_busy", 32'(busy), 32'd0);
                hs = 1'b0;
            end else if (!active && out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_out_valid: result %h presented, expected no output", result);
                end else begin
                    cur = q.pop_front();
                    check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                    active = 1'b1;
                    stall_left = cur.stall;
                end
            end
            if (active) begin
                check("result", result, cur.res);
                check("out_valid_held", 32'(out_valid), 32'd1);
                check("in_ready_in_done", 32'(in_ready), 32'd0);
                if (stall_left > 0) begin
                    stall_left--;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    active = 1'b0;
                    hs = 1'b1;
                end
            end else begin
                out_ready = out_valid;
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  d_op[12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a[12]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b[12]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd3, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        #1 rst_n = 1'b0;
        #10;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1, $urandom_range(0, 2));

        // Long backpressure in DONE.
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 10);

        // Asynchronous reset while iterating.
        issue(3'd4, 32'd1000, 32'd3, 1'b0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midop_reset_out_valid", 32'(out_valid), 32'd0);
        check("midop_reset_busy", 32'(busy), 32'd0);
        check("midop_reset_in_ready", 32'(in_ready), 32'd1);
        check("midop_reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flush at count 10; the aborted op must never present a result.
        issue(3'd4, 32'hFFFF_0000, 32'd7, 1'b0, 0);
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1 check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        issue(3'd5, 32'd100, 32'd7, 1'b1, 0);

        repeat (40) issue(3'($urandom), pick(), pick(), 1'b1, $urandom_range(0, 3));

        begin
            int w = 0;
            while ((q.size() != 0 || active || hs || busy) && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 2000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
